lcd1602_refresh_ctrl: RTL and testbench

//   HD44780/LCD1602 controller, successor to the single-char demo driver. Runs timed power-up + init,

---
 rtl/lcd1602_pkg.sv | 34 +++
 rtl/lcd_bus_xfer.sv | 112 +++++++++++
 rtl/lcd1602_refresh_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_lcd1602_refresh_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd1602_pkg.sv
// Shared definitions for the LCD1602 refresh controller.
//   - HD44780 command bytes used by the init sequence and the row addressing.
//   - State enums for the main sequencer and the bus transfer engine.
//   - A small integer max helper, used to size the cycle counters.
package lcd1602_pkg;

  localparam logic [7:0] FUNC_8B_2L = 8'h38;
  localparam logic [7:0] FUNC_8B_1L = 8'h30;
  localparam logic [7:0] DISP_ON    = 8'h0C;
  localparam logic [7:0] ENTRY_INC  = 8'h06;
  localparam logic [7:0] CLEAR      = 8'h01;
  localparam logic [7:0] DDRAM_ROW0 = 8'h80;
  localparam logic [7:0] DDRAM_ROW1 = 8'hC0;

  typedef enum logic [2:0] {
    S_PWR_WAIT,
    S_INIT,
    S_IDLE,
    S_ADDR,
    S_CHAR
  } main_state_e;

  typedef enum logic [1:0] {
    X_IDLE,
    X_SETUP,
    X_EN_HI,
    X_HOLD
  } xfer_state_e;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_bus_xfer.sv
// One HD44780 write cycle on the 8-bit bus.
//   start     in   1  begin a transfer (accepted only while idle)
//   rs        in   1  register select for this transfer
//   dat       in   8  data byte for this transfer
//   long_hold in   1  use CLR_CYC instead of HOLD after en falls
//   done      out  1  one-cycle pulse in the last hold cycle
//   lcd_rs/lcd_en/lcd_dat  out  LCD pins, all driven from flops
// rs/dat are captured at start and held unchanged through setup, the
// enable pulse and the hold window.
module lcd_bus_xfer
  import lcd1602_pkg::*;
#(
  parameter int SETUP   = 5,
  parameter int EN_HI   = 25,
  parameter int HOLD    = 2500,
  parameter int CLR_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] dat,
  input  logic       long_hold,
  output logic       done,
  output logic       lcd_rs,
  output logic       lcd_en,
  output logic [7:0] lcd_dat
);

  localparam int MAX_C = max_of(max_of(SETUP, EN_HI), max_of(HOLD, CLR_CYC));
  localparam int CNT_W = $clog2(MAX_C + 1);

  xfer_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hold_last;
  logic             rs_q, rs_d;
  logic             en_q, en_d;
  logic             long_q, long_d;
  logic [7:0]       dat_q, dat_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= X_IDLE;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      long_q  <= 1'b0;
      dat_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      en_q    <= en_d;
      long_q  <= long_d;
      dat_q   <= dat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rs_d      = rs_q;
    dat_d     = dat_q;
    long_d    = long_q;
    done      = 1'b0;
    hold_last = long_q ? CNT_W'(CLR_CYC - 1) : CNT_W'(HOLD - 1);
    case (state_q)
      X_IDLE: begin
        if (start) begin
          state_d = X_SETUP;
          cnt_d   = '0;
          rs_d    = rs;
          dat_d   = dat;
          long_d  = long_hold;
        end
      end
      X_SETUP: begin
        if (cnt_q == CNT_W'(SETUP - 1)) begin
          state_d = X_EN_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      X_EN_HI: begin
        if (cnt_q == CNT_W'(EN_HI - 1)) begin
          state_d = X_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      X_HOLD: begin
        if (cnt_q == hold_last) begin
          state_d = X_IDLE;
          cnt_d   = '0;
          done    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = X_IDLE;
    endcase
    // Registered enable so the pin is glitch-free and exactly EN_HI cycles wide.
    en_d = (state_d == X_EN_HI);
  end

  assign lcd_rs  = rs_q;
  assign lcd_en  = en_q;
  assign lcd_dat = dat_q;

endmodule

// File: rtl/lcd1602_refresh_ctrl.sv
// LCD1602 controller with an internal LINES x COLS character buffer.
// After a timed power-up wait and the four-command init, every time the
// buffer is dirty a full repaint pass is sent: per row a DDRAM address
// command followed by COLS data writes.
//   clk, rst                   clock, asynchronous active-high reset
//   wr_en/wr_row/wr_col/wr_char host character write (one per cycle)
//   init_done                  high once init has completed
//   busy                       high during init and repaint passes
//   lcd_rs/lcd_rw/lcd_en/lcd_dat  LCD pin header (rw is always 0)
module lcd1602_refresh_ctrl
  import lcd1602_pkg::*;
#(
  parameter int LINES   = 2,
  parameter int COLS    = 16,
  parameter int PWR_CYC = 750000,
  parameter int SETUP   = 5,
  parameter int EN_HI   = 25,
  parameter int HOLD    = 2500,
  parameter int CLR_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic       wr_row,
  input  logic [5:0] wr_col,
  input  logic [7:0] wr_char,
  output logic       init_done,
  output logic       busy,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_dat
);

  localparam int CNT_W = $clog2(max_of(max_of(PWR_CYC, CLR_CYC), HOLD) + 1);
  localparam int RW    = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;

  main_state_e      state_q, state_d;
  logic [CNT_W-1:0] pwr_cnt_q, pwr_cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [RW-1:0]    row_q, row_d;
  logic [CW-1:0]    col_q, col_d;
  logic             issued_q, issued_d;
  logic             dirty_q, dirty_d;
  logic             busy_q, busy_d;
  logic             init_done_q, init_done_d;
  logic [7:0]       chr_q [LINES][COLS];
  logic [7:0]       chr_d [LINES][COLS];

  logic             wr_ok;
  logic [RW-1:0]    wr_r;
  logic [CW-1:0]    wr_c;
  logic             x_start, x_rs, x_long, x_done;
  logic [7:0]       x_dat;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return (LINES == 1) ? FUNC_8B_1L : FUNC_8B_2L;
      2'd1:    return DISP_ON;
      2'd2:    return ENTRY_INC;
      default: return CLEAR;
    endcase
  endfunction

  assign wr_ok = wr_en && (int'(wr_row) < LINES) && (int'(wr_col) < COLS);
  assign wr_r  = RW'(wr_row);
  assign wr_c  = wr_col[CW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_PWR_WAIT;
      pwr_cnt_q   <= '0;
      idx_q       <= 2'd0;
      row_q       <= '0;
      col_q       <= '0;
      issued_q    <= 1'b0;
      dirty_q     <= 1'b1;
      busy_q      <= 1'b1;
      init_done_q <= 1'b0;
      for (int r = 0; r < LINES; r++)
        for (int c = 0; c < COLS; c++)
          chr_q[r][c] <= 8'h20;
    end else begin
      state_q     <= state_d;
      pwr_cnt_q   <= pwr_cnt_d;
      idx_q       <= idx_d;
      row_q       <= row_d;
      col_q       <= col_d;
      issued_q    <= issued_d;
      dirty_q     <= dirty_d;
      busy_q      <= busy_d;
      init_done_q <= init_done_d;
      chr_q       <= chr_d;
    end
  end

  always_comb begin
    chr_d = chr_q;
    if (wr_ok) chr_d[wr_r][wr_c] = wr_char;
  end

  always_comb begin
    state_d     = state_q;
    pwr_cnt_d   = pwr_cnt_q;
    idx_d       = idx_q;
    row_d       = row_q;
    col_d       = col_q;
    issued_d    = issued_q;
    dirty_d     = dirty_q;
    busy_d      = busy_q;
    init_done_d = init_done_q;
    x_rs        = 1'b0;
    x_dat       = 8'h00;
    x_long      = 1'b0;
    case (state_q)
      S_PWR_WAIT: begin
        if (pwr_cnt_q == CNT_W'(PWR_CYC - 1)) begin
          state_d   = S_INIT;
          pwr_cnt_d = '0;
        end else begin
          pwr_cnt_d = pwr_cnt_q + CNT_W'(1);
        end
      end
      S_INIT: begin
        x_dat  = init_cmd(idx_q);
        x_long = (idx_q == 2'd3);
        if (x_done) begin
          issued_d = 1'b0;
          if (idx_q == 2'd3) begin
            state_d     = S_IDLE;
            idx_d       = 2'd0;
            init_done_d = 1'b1;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      S_IDLE: begin
        if (dirty_q) begin
          dirty_d = 1'b0;
          busy_d  = 1'b1;
          row_d   = '0;
          col_d   = '0;
          state_d = S_ADDR;
        end else begin
          busy_d = 1'b0;
        end
      end
      S_ADDR: begin
        x_dat = (row_q == '0) ? DDRAM_ROW0 : DDRAM_ROW1;
        if (x_done) begin
          issued_d = 1'b0;
          col_d    = '0;
          state_d  = S_CHAR;
        end
      end
      S_CHAR: begin
        x_rs  = 1'b1;
        x_dat = chr_q[row_q][col_q];
        if (x_done) begin
          issued_d = 1'b0;
          if (col_q == CW'(COLS - 1)) begin
            col_d = '0;
            if (row_q == RW'(LINES - 1)) begin
              row_d   = '0;
              state_d = S_IDLE;
            end else begin
              row_d   = row_q + RW'(1);
              state_d = S_ADDR;
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      default: state_d = S_PWR_WAIT;
    endcase

    // One transfer per step: issue once, then wait for its done pulse.
    x_start = ((state_q == S_INIT) || (state_q == S_ADDR) || (state_q == S_CHAR)) && !issued_q;
    if (x_start) issued_d = 1'b1;

    // A write landing on the same edge as the IDLE clear must still trigger a pass.
    if (wr_ok) dirty_d = 1'b1;
  end

  lcd_bus_xfer #(
    .SETUP   (SETUP),
    .EN_HI   (EN_HI),
    .HOLD    (HOLD),
    .CLR_CYC (CLR_CYC)
  ) u_xfer (
    .clk       (clk),
    .rst       (rst),
    .start     (x_start),
    .rs        (x_rs),
    .dat       (x_dat),
    .long_hold (x_long),
    .done      (x_done),
    .lcd_rs    (lcd_rs),
    .lcd_en    (lcd_en),
    .lcd_dat   (lcd_dat)
  );

  assign lcd_rw    = 1'b0;
  assign init_done = init_done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_lcd1602_refresh_ctrl.sv
module tb_lcd1602_refresh_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic       w1_en = 1'b0;
  logic       wr_row = 1'b0;
  logic [5:0] wr_col = 6'd0;
  logic [7:0] wr_char = 8'h00;

  logic       init_done, busy, lcd_rs, lcd_rw, lcd_en;
  logic [7:0] lcd_dat;
  logic       init_done1, busy1, lcd_rs1, lcd_rw1, lcd_en1;
  logic [7:0] lcd_dat1;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int xfer_n = 0;
  int first_rise = -1;
  int clr_fall = -1;
  int rel_cyc = 0;
  int hi_cnt = 0;
  logic en_prev = 1'b0;
  logic en1_prev = 1'b0;
  logic got1 = 1'b0;
  logic [7:0] first_dat1 = 8'h00;
  logic [8:0] exp_v;
  logic [8:0] exp_q[$];
  logic [7:0] mbuf[2][16];

  lcd1602_refresh_ctrl #(
    .LINES(2), .COLS(16), .PWR_CYC(20), .SETUP(2), .EN_HI(4), .HOLD(8), .CLR_CYC(40)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
    .wr_char(wr_char), .init_done(init_done), .busy(busy), .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_dat(lcd_dat)
  );

  lcd1602_refresh_ctrl #(
    .LINES(1), .COLS(4), .PWR_CYC(20), .SETUP(2), .EN_HI(4), .HOLD(8), .CLR_CYC(40)
  ) dut1 (
    .clk(clk), .rst(rst), .wr_en(w1_en), .wr_row(wr_row), .wr_col(wr_col),
    .wr_char(wr_char), .init_done(init_done1), .busy(busy1), .lcd_rs(lcd_rs1),
    .lcd_rw(lcd_rw1), .lcd_en(lcd_en1), .lcd_dat(lcd_dat1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Bus monitor: every en rising edge pops one expected {rs,dat}.
  always @(negedge clk) begin
    if (rst) begin
      en_prev = 1'b0;
      hi_cnt  = 0;
    end else begin
      if (lcd_en && !en_prev) begin
        xfer_n++;
        if (first_rise < 0) first_rise = cyc;
        hi_cnt = 1;
        total++;
        assert (exp_q.size() != 0) else begin
          bad++;
          $error("FAIL xfer_extra got rs/dat=%03h required none", {lcd_rs, lcd_dat});
        end
        if (exp_q.size() != 0) begin
          exp_v = exp_q.pop_front();
          total++;
          assert ({lcd_rs, lcd_dat} === exp_v) else begin
            bad++;
            $error("FAIL xfer_data got rs/dat=%03h required %03h", {lcd_rs, lcd_dat}, exp_v);
          end
        end
      end else if (lcd_en) begin
        hi_cnt++;
      end else if (en_prev) begin
        total++;
        assert (hi_cnt == 4) else begin
          bad++;
          $error("FAIL en_width got %0d required 4", hi_cnt);
        end
        if ({lcd_rs, lcd_dat} == 9'h001) clr_fall = cyc;
      end
      en_prev = lcd_en;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      en1_prev = 1'b0;
    end else begin
      if (lcd_en1 && !en1_prev && !got1) begin
        got1       = 1'b1;
        first_dat1 = lcd_dat1;
      end
      en1_prev = lcd_en1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] req);
    total++;
    assert (got === req) else begin
      bad++;
      $error("FAIL %s got=%0h required=%0h", tag, got, req);
    end
  endtask

  task automatic write(input logic r, input int c, input logic [7:0] ch);
    wr_row  = r;
    wr_col  = 6'(c);
    wr_char = ch;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    if (c < 16) mbuf[r][c[3:0]] = ch;
  endtask

  task automatic model_clear();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 16; c++)
        mbuf[r][c] = 8'h20;
  endtask

  task automatic push_init();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h06});
    exp_q.push_back({1'b0, 8'h01});
  endtask

  task automatic push_pass();
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back({1'b0, (r == 0) ? 8'h80 : 8'hC0});
      for (int c = 0; c < 16; c++) exp_q.push_back({1'b1, mbuf[r][c]});
    end
  endtask

  task automatic wait_busy(input logic lvl, input int budget, input string tag);
    int n = 0;
    while (busy !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, busy}, {31'd0, lvl});
  endtask

  task automatic wait_init(input int budget, input string tag);
    int n = 0;
    while (init_done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, init_done}, 32'd1);
  endtask

  task automatic wait_xfer(input int target, input int budget, input string tag);
    int n = 0;
    while (xfer_n < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, xfer_n >= target}, 32'd1);
  endtask

  initial begin
    int n0;
    int base;
    int drops;
    int n;

    model_clear();
    repeat (3) @(negedge clk);
    chk("rst_en", {31'd0, lcd_en}, 32'd0);
    chk("rst_rs", {31'd0, lcd_rs}, 32'd0);
    chk("rst_rw", {31'd0, lcd_rw}, 32'd0);
    chk("rst_dat", {24'd0, lcd_dat}, 32'd0);
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd1);

    // Power-up, init, then the pass forced by the reset-time dirty flag.
    push_init();
    push_pass();
    rst = 1'b0;
    rel_cyc = cyc;
    wait_xfer(1, 200, "pwr_first_xfer");
    chk("pwr_wait_en_low", {31'd0, (first_rise - rel_cyc) >= 20}, 32'd1);
    wait_init(500, "init_done_rise");
    chk("init_done_delay", 32'(cyc - clr_fall), 32'd40);
    wait_busy(1'b0, 3000, "pass0_busy_low");
    chk("pass0_drained", 32'(exp_q.size()), 32'd0);
    chk("init_done_hold", {31'd0, init_done}, 32'd1);
    n0 = xfer_n;
    repeat (20) @(negedge clk);
    chk("bus_idle_xfers", 32'(xfer_n - n0), 32'd0);
    chk("bus_idle_en", {31'd0, lcd_en}, 32'd0);
    chk("u1_func_set", {24'd0, first_dat1}, 32'h30);
    n = 0;
    while (busy1 !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("u1_idle", {31'd0, busy1}, 32'd0);

    // Back-to-back writes: the second lands on the dirty-clear edge, so two passes.
    write(1'b0, 0, 8'h48);
    write(1'b1, 15, 8'h69);
    push_pass();
    push_pass();
    wait_busy(1'b1, 5, "pass1_start");
    wait_busy(1'b0, 4000, "pass1_end");
    chk("pass1_drained", 32'(exp_q.size()), 32'd0);

    // Write into row1 during row0 of a pass shows up in that pass; a row0
    // write during row1 chains a second pass without busy dropping.
    base = xfer_n;
    mbuf[1][3] = 8'h5A;
    write(1'b0, 5, 8'h41);
    push_pass();
    wait_xfer(base + 3, 1000, "pass2_row0");
    write(1'b1, 3, 8'h5A);
    wait_xfer(base + 20, 1000, "pass2_row1");
    write(1'b0, 0, 8'h51);
    push_pass();
    drops = 0;
    n = 0;
    while (exp_q.size() > 0 && n < 6000) begin
      if (busy !== 1'b1) drops++;
      @(negedge clk);
      n++;
    end
    chk("chain_busy_held", 32'(drops), 32'd0);
    chk("chain_drained", 32'(exp_q.size()), 32'd0);
    wait_busy(1'b0, 200, "chain_end");

    // Out-of-range writes are ignored.
    n0 = xfer_n;
    write(1'b0, 20, 8'h58);
    drops = 0;
    repeat (30) begin
      if (busy !== 1'b0) drops++;
      @(negedge clk);
    end
    chk("bad_col_busy", 32'(drops), 32'd0);
    chk("bad_col_xfers", 32'(xfer_n - n0), 32'd0);
    wr_row = 1'b1;
    wr_col = 6'd0;
    wr_char = 8'h58;
    w1_en = 1'b1;
    @(negedge clk);
    w1_en = 1'b0;
    drops = 0;
    repeat (30) begin
      if (busy1 !== 1'b0) drops++;
      @(negedge clk);
    end
    chk("u1_bad_row_busy", 32'(drops), 32'd0);

    // Reset while en is high mid-pass.
    write(1'b1, 9, 8'h58);
    n = 0;
    while (lcd_en !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("pass3_en_high", {31'd0, lcd_en}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_en", {31'd0, lcd_en}, 32'd0);
    chk("rst_async_init_done", {31'd0, init_done}, 32'd0);
    chk("rst_async_busy", {31'd0, busy}, 32'd1);
    exp_q.delete();
    model_clear();
    push_init();
    push_pass();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_init(500, "reinit_done");
    wait_busy(1'b0, 3000, "repass_end");
    chk("repass_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
